// File: rtl/rr_arb4_sel_pkg.sv
// Shared constants, FSM state encoding and a one-hot helper for the 4-way arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rr_arb4_sel_pkg;

  localparam int NUM_SRC = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  // Index to one-hot grant vector.
  function automatic logic [NUM_SRC-1:0] onehot4(input logic [SEL_W-1:0] idx);
    logic [NUM_SRC-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Round-robin pick: first set req bit scanning ptr, ptr+1, ... modulo 4.
// Latency: purely combinational.
// Backpressure: none; caller decides when the winner is used.
//
// Ports:
//   req    in  4  candidate request vector
//   ptr    in  2  highest-priority index for this scan
//   winner out 2  selected index (equals ptr when any=0, value unused then)
//   any    out 1  at least one request present
module rr_pick4
  import rr_arb4_sel_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [SEL_W-1:0]   winner,
  output logic               any
);

  // Walk offsets from farthest to nearest so the nearest set bit to ptr
  // is the last assignment and therefore wins.
  always_comb begin
    winner = ptr;
    any    = |req;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[ptr + SEL_W'(i)]) begin
        winner = ptr + SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/rr_arb4_sel.sv
// Round-robin 4-source frame arbiter driving the select of a shared 4:1 datapath mux.
// Latency: req to out_valid 1 cycle; one idle bubble between consecutive frames.
// Backpressure: dst_ready low stalls the owner (grant held, no beat counted); src_ready = gnt & dst_ready.
//
// Ports:
//   clk          in   1  system clock
//   reset_l      in   1  asynchronous active-low reset
//   req          in   4  per-source beat valid
//   eop          in   4  per-source end-of-frame, qualified by req
//   dst_ready    in   1  downstream accepts the current beat
//   sel          out  2  registered mux select, stable for a whole frame
//   gnt          out  4  one-hot datapath owner, zero when idle
//   src_ready    out  4  per-source pop strobe
//   out_valid    out  1  beat valid toward downstream
//   out_eop      out  1  end-of-frame on the current beat
//   timeout_err  out  1  one-cycle pulse on watchdog release
module rr_arb4_sel
  import rr_arb4_sel_pkg::*;
#(
  parameter int MAX_BEATS = 256,
  parameter int CNT_W     = 9
) (
  input  logic               clk,
  input  logic               reset_l,
  input  logic [NUM_SRC-1:0] req,
  input  logic [NUM_SRC-1:0] eop,
  input  logic               dst_ready,
  output logic [SEL_W-1:0]   sel,
  output logic [NUM_SRC-1:0] gnt,
  output logic [NUM_SRC-1:0] src_ready,
  output logic               out_valid,
  output logic               out_eop,
  output logic               timeout_err
);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BEATS - 1);

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [SEL_W-1:0]   sel_d;
  logic [NUM_SRC-1:0] gnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               tmo_d;

  logic [SEL_W-1:0]   pick_win;
  logic               pick_any;
  logic               xfer;

  rr_pick4 u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .winner (pick_win),
    .any    (pick_any)
  );

  // Handshake toward the datapath; only the owner's request is visible.
  assign out_valid = (state_q == LOCK) & req[sel];
  assign out_eop   = out_valid & eop[sel];
  assign src_ready = gnt & {NUM_SRC{dst_ready}};
  assign xfer      = out_valid & dst_ready;

  always_comb begin
    state_d = state_q;
    sel_d   = sel;
    gnt_d   = gnt;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          sel_d   = pick_win;
          gnt_d   = onehot4(pick_win);
          cnt_d   = '0;
          state_d = LOCK;
        end
      end
      LOCK: begin
        if (xfer) begin
          if (eop[sel] || (cnt_q == LAST_BEAT)) begin
            // Release; the served source drops to lowest priority.
            state_d = IDLE;
            gnt_d   = '0;
            ptr_d   = sel + SEL_W'(1);
            tmo_d   = ~eop[sel];
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q     <= IDLE;
      sel         <= '0;
      gnt         <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel         <= sel_d;
      gnt         <= gnt_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      timeout_err <= tmo_d;
    end
  end

endmodule

// File: tb/tb_rr_arb4_sel.sv
module tb_rr_arb4_sel;

  logic       clk;
  logic       reset_l;
  logic [3:0] req;
  logic [3:0] eop;
  logic       dst_ready;
  logic [1:0] sel;
  logic [3:0] gnt;
  logic [3:0] src_ready;
  logic       out_valid;
  logic       out_eop;
  logic       timeout_err;

  rr_arb4_sel #(.MAX_BEATS(4), .CNT_W(3)) dut (
    .clk         (clk),
    .reset_l     (reset_l),
    .req         (req),
    .eop         (eop),
    .dst_ready   (dst_ready),
    .sel         (sel),
    .gnt         (gnt),
    .src_ready   (src_ready),
    .out_valid   (out_valid),
    .out_eop     (out_eop),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs packed as {gnt, sel, out_valid, src_ready, out_eop, timeout_err}.
  typedef struct {
    string       nm;
    logic [3:0]  rq;
    logic [3:0]  ep;
    logic        rd;
    logic [12:0] ex;
  } vec_t;

  vec_t        vecs[$];
  logic [12:0] sb_exp[$];
  string       sb_nm[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          vec_idx  = 0;

  function automatic vec_t mk(input string nm, input logic [3:0] rq, input logic [3:0] ep,
                              input logic rd, input logic [3:0] g, input logic [1:0] s,
                              input logic ov, input logic [3:0] sr, input logic oe,
                              input logic to);
    vec_t v;
    v.nm = nm;
    v.rq = rq;
    v.ep = ep;
    v.rd = rd;
    v.ex = {g, s, ov, sr, oe, to};
    return v;
  endfunction

  function automatic void add(input string nm, input logic [3:0] rq, input logic [3:0] ep,
                              input logic rd, input logic [3:0] g, input logic [1:0] s,
                              input logic ov, input logic [3:0] sr, input logic oe,
                              input logic to);
    vecs.push_back(mk(nm, rq, ep, rd, g, s, ov, sr, oe, to));
  endfunction

  task automatic compare(input string nm, input logic [12:0] ex);
    logic [12:0] obs;
    obs = {gnt, sel, out_valid, src_ready, out_eop, timeout_err};
    n_checks++;
    if (obs === ex) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got gnt=%b sel=%0d ov=%b srdy=%b eop=%b tmo=%b, want gnt=%b sel=%0d ov=%b srdy=%b eop=%b tmo=%b",
               nm, obs[12:9], obs[8:7], obs[6], obs[5:2], obs[1], obs[0],
               ex[12:9], ex[8:7], ex[6], ex[5:2], ex[1], ex[0]);
    end
  endtask

  // Called just after a rising edge: drive, queue expectation, check mid-cycle.
  task automatic apply(input vec_t v);
    req       = v.rq;
    eop       = v.ep;
    dst_ready = v.rd;
    sb_exp.push_back(v.ex);
    sb_nm.push_back($sformatf("%s#%0d", v.nm, vec_idx));
    vec_idx++;
    @(negedge clk);
    compare(sb_nm.pop_front(), sb_exp.pop_front());
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1);
  end

  initial begin
    //    name     req    eop    rdy | gnt    sel ov srdy   oeop tmo
    add("idle0",  4'h0, 4'h0, 1'b0,  4'h0, 2'd0, 0, 4'h0, 0, 0);
    // single-beat frame from source 0
    add("t1",     4'h1, 4'h1, 1'b1,  4'h0, 2'd0, 0, 4'h0, 0, 0);
    add("t1",     4'h1, 4'h1, 1'b1,  4'h1, 2'd0, 1, 4'h1, 1, 0);
    add("t1",     4'h0, 4'h0, 1'b1,  4'h0, 2'd0, 0, 4'h0, 0, 0);
    // all sources requesting, single-beat frames: rotation from ptr=1
    add("t2rr",   4'hF, 4'hF, 1'b1,  4'h0, 2'd0, 0, 4'h0, 0, 0);
    add("t2rr",   4'hF, 4'hF, 1'b1,  4'h2, 2'd1, 1, 4'h2, 1, 0);
    add("t2rr",   4'hF, 4'hF, 1'b1,  4'h0, 2'd1, 0, 4'h0, 0, 0);
    add("t2rr",   4'hF, 4'hF, 1'b1,  4'h4, 2'd2, 1, 4'h4, 1, 0);
    add("t2rr",   4'hF, 4'hF, 1'b1,  4'h0, 2'd2, 0, 4'h0, 0, 0);
    add("t2rr",   4'hF, 4'hF, 1'b1,  4'h8, 2'd3, 1, 4'h8, 1, 0);
    add("t2rr",   4'hF, 4'hF, 1'b1,  4'h0, 2'd3, 0, 4'h0, 0, 0);
    add("t2rr",   4'hF, 4'hF, 1'b1,  4'h1, 2'd0, 1, 4'h1, 1, 0);
    add("t2rr",   4'hF, 4'hF, 1'b1,  4'h0, 2'd0, 0, 4'h0, 0, 0);
    add("t2rr",   4'hF, 4'hF, 1'b1,  4'h2, 2'd1, 1, 4'h2, 1, 0);
    add("t2rr",   4'h0, 4'h0, 1'b1,  4'h0, 2'd1, 0, 4'h0, 0, 0);
    // source 2 three beats with dst_ready toggling; source 0 waits
    add("t3stall",4'h5, 4'h0, 1'b1,  4'h0, 2'd1, 0, 4'h0, 0, 0);
    add("t3stall",4'h5, 4'h0, 1'b1,  4'h4, 2'd2, 1, 4'h4, 0, 0);
    add("t3stall",4'h5, 4'h0, 1'b0,  4'h4, 2'd2, 1, 4'h0, 0, 0);
    add("t3stall",4'h5, 4'h0, 1'b1,  4'h4, 2'd2, 1, 4'h4, 0, 0);
    add("t3stall",4'h5, 4'h0, 1'b0,  4'h4, 2'd2, 1, 4'h0, 0, 0);
    add("t3stall",4'h5, 4'h4, 1'b1,  4'h4, 2'd2, 1, 4'h4, 1, 0);
    add("t3stall",4'h1, 4'h0, 1'b1,  4'h0, 2'd2, 0, 4'h0, 0, 0);
    add("t3stall",4'h1, 4'h1, 1'b1,  4'h1, 2'd0, 1, 4'h1, 1, 0);
    // source 1 drops req for 5 cycles; req/eop of others and stray eop ignored
    add("t4drop", 4'h2, 4'h0, 1'b1,  4'h0, 2'd0, 0, 4'h0, 0, 0);
    add("t4drop", 4'h2, 4'h0, 1'b1,  4'h2, 2'd1, 1, 4'h2, 0, 0);
    for (int i = 0; i < 5; i++)
      add("t4drop", 4'h8, 4'hA, 1'b1, 4'h2, 2'd1, 0, 4'h2, 0, 0);
    add("t4drop", 4'hA, 4'h0, 1'b1,  4'h2, 2'd1, 1, 4'h2, 0, 0);
    add("t4drop", 4'hA, 4'h0, 1'b1,  4'h2, 2'd1, 1, 4'h2, 0, 0);
    // fourth beat carries eop: normal release, no timeout
    add("t4drop", 4'hA, 4'h2, 1'b1,  4'h2, 2'd1, 1, 4'h2, 1, 0);
    // source 3 streams without eop: forced release after 4 accepted beats
    add("t5wd",   4'h8, 4'h0, 1'b1,  4'h0, 2'd1, 0, 4'h0, 0, 0);
    add("t5wd",   4'h8, 4'h0, 1'b1,  4'h8, 2'd3, 1, 4'h8, 0, 0);
    add("t5wd",   4'h8, 4'h0, 1'b1,  4'h8, 2'd3, 1, 4'h8, 0, 0);
    add("t5wd",   4'h8, 4'h0, 1'b0,  4'h8, 2'd3, 1, 4'h0, 0, 0);
    add("t5wd",   4'h8, 4'h0, 1'b1,  4'h8, 2'd3, 1, 4'h8, 0, 0);
    add("t5wd",   4'h8, 4'h0, 1'b1,  4'h8, 2'd3, 1, 4'h8, 0, 0);
    add("t5wd",   4'h9, 4'h0, 1'b1,  4'h0, 2'd3, 0, 4'h0, 0, 1);
    add("t5wd",   4'h9, 4'h1, 1'b1,  4'h1, 2'd0, 1, 4'h1, 1, 0);
    add("t5wd",   4'h0, 4'h0, 1'b1,  4'h0, 2'd0, 0, 4'h0, 0, 0);

    reset_l   = 1'b0;
    req       = 4'h0;
    eop       = 4'h0;
    dst_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    compare("in_reset", 13'h0);
    @(negedge clk);
    reset_l = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) apply(vecs[i]);

    // Reset mid-frame: grant 2 (ptr=1), then async reset between edges.
    apply(mk("t6rst", 4'h4, 4'h0, 1'b1, 4'h0, 2'd0, 0, 4'h0, 0, 0));
    apply(mk("t6rst", 4'h4, 4'h0, 1'b1, 4'h4, 2'd2, 1, 4'h4, 0, 0));
    #1;
    reset_l = 1'b0;
    #1;
    compare("t6async", 13'h0);
    req = 4'h0;
    @(negedge clk);
    reset_l = 1'b1;
    @(posedge clk);
    #1;
    // ptr back to 0: source 0 beats source 3
    apply(mk("t6post", 4'h9, 4'h0, 1'b1, 4'h0, 2'd0, 0, 4'h0, 0, 0));
    apply(mk("t6post", 4'h9, 4'h1, 1'b1, 4'h1, 2'd0, 1, 4'h1, 1, 0));
    apply(mk("t6post", 4'h8, 4'h0, 1'b1, 4'h0, 2'd0, 0, 4'h0, 0, 0));
    apply(mk("t6post", 4'h8, 4'h8, 1'b1, 4'h8, 2'd3, 1, 4'h8, 1, 0));
    apply(mk("t6post", 4'h0, 4'h0, 1'b0, 4'h0, 2'd3, 0, 4'h0, 0, 0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rr_arb4_sel.md
Name: rr_arb4_sel

Overview:
- Round-robin 4-source packet arbiter.
- Drives the 2-bit select of the downstream 4:1 datapath mux (dwidth-wide) and the framing/handshake around it.
- Holds a grant for a whole frame (until EOP beat accepted), then rotates priority.
- Sits between four per-channel Ethernet transmit queues and the shared mux/MAC datapath.

Parameters:
- MAX_BEATS, 256, maximum beats per frame before a forced release (watchdog).
- CNT_W, 9, beat counter width; must satisfy 2^CNT_W > MAX_BEATS.

Ports:
- clk  in  1  system clock
- reset_l  in  1  asynchronous active-low reset
- req  in  4  per-source beat valid; bit i = source i has a beat presented
- eop  in  4  per-source end-of-frame flag, qualified by req[i]
- dst_ready  in  1  downstream accepts the current beat
- sel  out  2  mux select to the downstream 4:1 mux; registered
- gnt  out  4  one-hot owner of the datapath; all zero when idle
- src_ready  out  4  per-source pop strobe: gnt[i] & dst_ready
- out_valid  out  1  beat valid toward downstream: req[sel] & gnt active
- out_eop  out  1  eop[sel] & out_valid
- timeout_err  out  1  one-cycle pulse on watchdog release

Behaviour:
- Reset (async assert, sync-released use): state=IDLE, sel=0, gnt=0, ptr=0, beat_cnt=0, timeout_err=0. Combinational outputs src_ready, out_valid and out_eop evaluate to 0 because gnt=0.
- States: IDLE, LOCK.
- IDLE:
  - If req != 0, pick the first set bit scanning ptr, ptr+1, ... mod 4.
  - On the next edge: sel<=winner, gnt<=onehot(winner), beat_cnt<=0, state<=LOCK.
  - No beat is accepted in IDLE. Latency from req to out_valid is 1 cycle.
  - If req==0, stay in IDLE; sel holds its last value.
- LOCK:
  - out_valid=req[sel]. A beat transfers when out_valid & dst_ready; src_ready[sel] pulses in the same cycle.
  - On a transfer, beat_cnt increments (saturating is not required, since release occurs first).
  - Transfer with eop[sel]=1: next edge state<=IDLE, gnt<=0, ptr<=sel+1 (2-bit wrap, 3->0).
  - Transfer with eop=0 and beat_cnt==MAX_BEATS-1: forced release. Same updates as EOP, plus timeout_err=1 for one cycle.
  - Owner drops req mid-frame: out_valid=0, grant held, no counting. Other sources' req are ignored.
  - dst_ready low: grant held, no counting.
- Priority rule: the just-served source gets lowest priority. The ptr update uses the served index, not the scan start.
- No back-to-back grant: at least one IDLE cycle between frames, giving a 1-cycle bubble per frame.
- A reset asserted mid-frame drops the grant immediately and returns to IDLE with ptr=0. The partial frame is the upstream's responsibility.
- sel changes only on the IDLE->LOCK edge, so it is stable for the whole frame. The downstream mux sees no select glitch within a frame.
- The unused combinations req=0 in LOCK and eop without req have no effect.

Decomposition:
- Shared package constants:
  - state encoding: IDLE=1'b0, LOCK=1'b1
  - NUM_SRC=4
  - SEL_W=2
- One natural sub-module: rr_pick4. It is combinational: given req[3:0] and ptr[1:0], it returns winner[1:0] and any. It is reusable by other 4-way schedulers.
- The FSM, counter and handshake logic stay in the top.

Test Plan:
- Reset then req=4'b0001, eop=1 on first beat, dst_ready=1 -> gnt=0001 and sel=0 one cycle later; out_valid=1 and src_ready=0001 for one cycle; gnt=0 next cycle; ptr=1.
- req=4'b1111 held, every beat eop=1, dst_ready=1 -> grant order 0,1,2,3,0, with each frame followed by one idle bubble.
- Source 2 sends a 3-beat frame with dst_ready toggling 1,0,1,0,1 -> exactly 3 src_ready[2] pulses; sel=2 throughout; release after the third beat. Assert req[0]=1 meanwhile -> source 0 is served only after source 2 releases.
- Source 1 is granted, then drops req for 5 cycles mid-frame while req[3]=1 -> gnt stays 0010 and out_valid=0 for 5 cycles; the frame resumes and completes.
- MAX_BEATS=4 override, source 3 streams without eop -> release after the 4th accepted beat; timeout_err pulses once; next winner search starts at 0.
- Assert reset_l low in LOCK mid-frame -> gnt, sel, out_valid and timeout_err go to 0 asynchronously; after release, req=4'b1000 gives sel=3 with ptr reset to 0.
